// File: rtl/io_fmt_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : io_fmt_seq                                                       |
// | Purpose  : Slow-output format sequencer; walks packed format codes and      |
// |            emits digit/sign/control characters over valid/ready.            |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module io_fmt_seq #(
    parameter int WORD_W  = 29,
    parameter int CODE_W  = 3,
    parameter int DIGIT_W = 4
) (
    input  logic               CLOCK,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [WORD_W-1:0]  fmt_word,
    input  logic [WORD_W-1:0]  data_word,
    input  logic               char_ready,
    output logic               char_valid,
    output logic [1:0]         char_kind,
    output logic [DIGIT_W-1:0] char_data,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [7:0]         passes
);

    localparam int c_NCODES = WORD_W / CODE_W;
    localparam int c_MAG_W  = WORD_W - 1;
    localparam int c_IDX_W  = $clog2(c_NCODES + 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_EMIT  = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam logic [CODE_W-1:0] c_OP_DIGIT  = CODE_W'(0);
    localparam logic [CODE_W-1:0] c_OP_SIGN   = CODE_W'(1);
    localparam logic [CODE_W-1:0] c_OP_CR     = CODE_W'(2);
    localparam logic [CODE_W-1:0] c_OP_TAB    = CODE_W'(3);
    localparam logic [CODE_W-1:0] c_OP_STOP   = CODE_W'(4);
    localparam logic [CODE_W-1:0] c_OP_RELOAD = CODE_W'(5);
    localparam logic [CODE_W-1:0] c_OP_WAIT   = CODE_W'(7);

    localparam logic [1:0] c_KIND_DIGIT  = 2'd0;
    localparam logic [1:0] c_KIND_SIGN   = 2'd1;
    localparam logic [1:0] c_KIND_CR_TAB = 2'd2;
    localparam logic [1:0] c_KIND_WAIT   = 2'd3;

    logic [1:0]          r_state;
    logic [WORD_W-1:0]   r_fmt_work;
    logic [WORD_W-1:0]   r_fmt_save;
    logic [c_MAG_W-1:0]  r_mag;
    logic                r_sign;
    logic [c_IDX_W-1:0]  r_idx;
    logic                r_digit_seen;
    logic [1:0]          r_kind;
    logic [DIGIT_W-1:0]  r_data;
    logic                r_err;
    logic [7:0]          r_passes;

    logic [1:0]          w_state_nxt;
    logic [CODE_W-1:0]   w_code;
    logic                w_exhausted;
    logic                w_is_stop;
    logic                w_reload_req;
    logic                w_accept;
    logic                w_load_char;
    logic [1:0]          w_kind_nxt;
    logic [DIGIT_W-1:0]  w_data_nxt;
    logic                w_shift_mag;
    logic                w_advance;
    logic                w_reload;
    logic                w_set_err;

    assign w_code       = r_fmt_work[CODE_W-1:0];
    assign w_exhausted  = (r_idx == c_IDX_W'(c_NCODES));
    assign w_is_stop    = w_exhausted || (w_code == c_OP_STOP);
    // A STOP with magnitude left over restarts the format for another pass.
    assign w_reload_req = (w_is_stop && (|r_mag)) || (!w_exhausted && (w_code == c_OP_RELOAD));

    always_ff @(posedge CLOCK or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_load_char = 1'b0;
        w_kind_nxt  = c_KIND_DIGIT;
        w_data_nxt  = '0;
        w_shift_mag = 1'b0;
        w_advance   = 1'b0;
        w_reload    = 1'b0;
        w_set_err   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_ST_FETCH;
                end
            end
            c_ST_FETCH: begin
                if (w_reload_req) begin
                    // A pass that produced no digit would loop forever.
                    if (!r_digit_seen) begin
                        w_set_err   = 1'b1;
                        w_state_nxt = c_ST_DONE;
                    end else begin
                        w_reload = 1'b1;
                    end
                end else if (w_is_stop) begin
                    w_state_nxt = c_ST_DONE;
                end else begin
                    case (w_code)
                        c_OP_DIGIT: begin
                            w_load_char = 1'b1;
                            w_kind_nxt  = c_KIND_DIGIT;
                            w_data_nxt  = r_mag[c_MAG_W-1 -: DIGIT_W];
                            w_shift_mag = 1'b1;
                            w_state_nxt = c_ST_EMIT;
                        end
                        c_OP_SIGN: begin
                            w_load_char = 1'b1;
                            w_kind_nxt  = c_KIND_SIGN;
                            w_data_nxt  = {{(DIGIT_W-1){1'b0}}, r_sign};
                            w_state_nxt = c_ST_EMIT;
                        end
                        c_OP_CR, c_OP_TAB: begin
                            w_load_char = 1'b1;
                            w_kind_nxt  = c_KIND_CR_TAB;
                            w_state_nxt = c_ST_EMIT;
                        end
                        c_OP_WAIT: begin
                            w_load_char = 1'b1;
                            w_kind_nxt  = c_KIND_WAIT;
                            w_state_nxt = c_ST_EMIT;
                        end
                        default: begin
                            w_advance = 1'b1;
                        end
                    endcase
                end
            end
            c_ST_EMIT: begin
                if (char_ready) begin
                    w_advance   = 1'b1;
                    w_state_nxt = c_ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
        if (abort) begin
            w_state_nxt = c_ST_IDLE;
            w_accept    = 1'b0;
            w_load_char = 1'b0;
            w_shift_mag = 1'b0;
            w_advance   = 1'b0;
            w_reload    = 1'b0;
            w_set_err   = 1'b0;
        end
    end

    always_ff @(posedge CLOCK or negedge rst) begin
        if (!rst) begin
            r_fmt_work   <= '0;
            r_fmt_save   <= '0;
            r_mag        <= '0;
            r_sign       <= 1'b0;
            r_idx        <= '0;
            r_digit_seen <= 1'b0;
            r_kind       <= 2'd0;
            r_data       <= '0;
            r_err        <= 1'b0;
            r_passes     <= 8'd0;
        end else begin
            if (w_accept) begin
                r_fmt_work   <= fmt_word;
                r_fmt_save   <= fmt_word;
                r_mag        <= data_word[WORD_W-1:1];
                r_sign       <= data_word[0];
                r_idx        <= '0;
                r_digit_seen <= 1'b0;
                r_err        <= 1'b0;
                r_passes     <= 8'd1;
            end
            if (w_load_char) begin
                r_kind <= w_kind_nxt;
                r_data <= w_data_nxt;
            end
            if (w_shift_mag) begin
                r_mag        <= r_mag << DIGIT_W;
                r_digit_seen <= 1'b1;
            end
            if (w_advance) begin
                r_idx      <= r_idx + c_IDX_W'(1);
                r_fmt_work <= r_fmt_work >> CODE_W;
            end
            if (w_reload) begin
                r_idx        <= '0;
                r_fmt_work   <= r_fmt_save;
                r_digit_seen <= 1'b0;
                if (r_passes != 8'hFF) begin
                    r_passes <= r_passes + 8'd1;
                end
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign char_valid = (r_state == c_ST_EMIT);
    assign char_kind  = r_kind;
    assign char_data  = r_data;
    assign busy       = (r_state != c_ST_IDLE);
    assign done       = (r_state == c_ST_DONE);
    assign err        = r_err;
    assign passes     = r_passes;

endmodule
`default_nettype wire

// File: tb/tb_io_fmt_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_io_fmt_seq                                                    |
// | Purpose  : Self-checking bench: vector table, corner sequences, random runs |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_io_fmt_seq;
    localparam int WORD_W  = 29;
    localparam int CODE_W  = 3;
    localparam int DIGIT_W = 4;
    localparam int NCODES  = WORD_W / CODE_W;
    localparam int MAG_W   = WORD_W - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               char_ready = 1'b0;
    logic [WORD_W-1:0]  fmt_word = '0;
    logic [WORD_W-1:0]  data_word = '0;
    logic               char_valid;
    logic [1:0]         char_kind;
    logic [DIGIT_W-1:0] char_data;
    logic               busy;
    logic               done;
    logic               err;
    logic [7:0]         passes;

    io_fmt_seq #(.WORD_W(WORD_W), .CODE_W(CODE_W), .DIGIT_W(DIGIT_W)) dut (
        .CLOCK(clk), .rst(rst), .start(start), .abort(abort),
        .fmt_word(fmt_word), .data_word(data_word), .char_ready(char_ready),
        .char_valid(char_valid), .char_kind(char_kind), .char_data(char_data),
        .busy(busy), .done(done), .err(err), .passes(passes)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [1:0]         obs_kind[$];
    logic [DIGIT_W-1:0] obs_data[$];
    logic [1:0]         exp_kind[$];
    logic [DIGIT_W-1:0] exp_data[$];
    int                 got_cyc;
    int                 got_stalls;
    logic               got_err;
    logic [7:0]         got_passes;

    typedef struct {
        logic [WORD_W-1:0] fmt;
        logic [WORD_W-1:0] data;
        int                nchar;
        logic [19:0]       kinds;
        logic [39:0]       datas;
        int                npass;
        logic              e;
        int                cycles;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [WORD_W-1:0] f, input logic [WORD_W-1:0] d,
                                input int n, input logic [19:0] k, input logic [39:0] dd,
                                input int p, input logic e, input int c);
        vec_t v;
        v.fmt = f; v.data = d; v.nchar = n; v.kinds = k; v.datas = dd;
        v.npass = p; v.e = e; v.cycles = c;
        return v;
    endfunction

    // Reference: interpret the format word code by code with plain arithmetic.
    task automatic model(input logic [WORD_W-1:0] f, input logic [WORD_W-1:0] d,
                         output int fetches, output int npass, output logic e);
        longint mag;
        int     idx;
        int     code;
        bit     seen;
        mag = longint'(d) / 2;
        idx = 0; seen = 0; fetches = 0; npass = 1; e = 1'b0;
        exp_kind.delete(); exp_data.delete();
        for (int guard = 0; guard < 5000; guard++) begin
            fetches++;
            code = (idx == NCODES) ? 4 : int'(f[CODE_W*idx +: CODE_W]);
            if (code == 4 && mag != 0) code = 5;
            if (code == 4) break;
            if (code == 5) begin
                if (!seen) begin e = 1'b1; break; end
                idx = 0; seen = 0;
                npass = (npass < 255) ? npass + 1 : 255;
                continue;
            end
            case (code)
                0: begin
                    exp_kind.push_back(2'd0);
                    exp_data.push_back(DIGIT_W'(mag / (64'd1 << (MAG_W - DIGIT_W))));
                    mag  = (mag * 16) % (64'd1 << MAG_W);
                    seen = 1;
                end
                1: begin exp_kind.push_back(2'd1); exp_data.push_back(DIGIT_W'(d[0])); end
                2, 3: begin exp_kind.push_back(2'd2); exp_data.push_back('0); end
                7: begin exp_kind.push_back(2'd3); exp_data.push_back('0); end
                default: ;
            endcase
            idx++;
        end
    endtask

    // Starts a sequence from IDLE (called at a negedge) and records every transfer.
    task automatic run_seq(input string name, input logic [WORD_W-1:0] f,
                           input logic [WORD_W-1:0] d, input bit rnd);
        logic               stalled;
        logic [1:0]         hk;
        logic [DIGIT_W-1:0] hd;
        obs_kind.delete(); obs_data.delete();
        got_cyc = -1; got_stalls = 0; got_err = 1'bx; got_passes = 'x;
        stalled = 1'b0; hk = '0; hd = '0;
        fmt_word = f; data_word = d; start = 1'b1; char_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if (stalled)
                chk({name, " hold"}, {char_valid, char_kind, char_data}, {1'b1, hk, hd});
            if (done) begin
                got_cyc = k; got_err = err; got_passes = passes;
                chk({name, " busy at done"}, busy, 1);
                break;
            end
            char_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            stalled = 1'b0;
            if (char_valid) begin
                if (char_ready) begin
                    obs_kind.push_back(char_kind);
                    obs_data.push_back(char_data);
                end else begin
                    stalled = 1'b1; hk = char_kind; hd = char_data; got_stalls++;
                end
            end
            @(negedge clk);
        end
        if (got_cyc < 0) begin
            checks++; errors++;
            $display("FAIL %s timeout: done not seen within budget", name);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
        char_ready = 1'b1;
        @(negedge clk);
        chk({name, " idle after done"}, {busy, done, char_valid}, 3'b000);
    endtask

    task automatic compare(input string name, input int e_cyc, input int e_pass, input logic e_err);
        chk({name, " nchars"}, obs_kind.size(), exp_kind.size());
        for (int i = 0; i < exp_kind.size() && i < obs_kind.size(); i++) begin
            chk($sformatf("%s char%0d kind", name, i), obs_kind[i], exp_kind[i]);
            chk($sformatf("%s char%0d data", name, i), obs_data[i], exp_data[i]);
        end
        chk({name, " passes"}, got_passes, e_pass);
        chk({name, " err"}, got_err, e_err);
        chk({name, " cycles"}, got_cyc, e_cyc + got_stalls);
    endtask

    task automatic load_vec(input int i);
        exp_kind.delete(); exp_data.delete();
        for (int j = 0; j < vecs[i].nchar; j++) begin
            exp_kind.push_back(vecs[i].kinds[2*j +: 2]);
            exp_data.push_back(vecs[i].datas[4*j +: 4]);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WORD_W-1:0] f;
        logic [WORD_W-1:0] d;
        logic [2:0]        c;
        int                fe;
        int                ep;
        logic              ee;

        vecs[0] = mk(29'h108,   29'h1E000001, 2, 20'h4,  40'h1F,         1, 1'b0, 5);
        vecs[1] = mk(29'h005,   29'h00000002, 0, 20'h0,  40'h0,          1, 1'b1, 1);
        vecs[2] = mk(29'h020,   29'h1FE00000, 2, 20'h0,  40'hFF,         2, 1'b0, 6);
        vecs[3] = mk(29'h21DDA, 29'h00000001, 4, 20'h7A, 40'h1000,       1, 1'b0, 10);
        vecs[4] = mk(29'h0,     29'h02468ACF, 9, 20'h0,  40'h0007654321, 1, 1'b0, 19);
        vecs[5] = mk(29'h004,   29'h00000010, 0, 20'h0,  40'h0,          1, 1'b1, 1);

        repeat (3) @(negedge clk);
        chk("reset outputs", {char_valid, char_kind, char_data, busy, done, err, passes}, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle outputs", {char_valid, char_kind, char_data, busy, done, err, passes}, 0);

        for (int i = 0; i < 6; i++) begin
            load_vec(i);
            run_seq($sformatf("vec%0d", i), vecs[i].fmt, vecs[i].data, 1'b0);
            compare($sformatf("vec%0d", i), vecs[i].cycles, vecs[i].npass, vecs[i].e);
        end

        // err is sticky across an abort while idle
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("err after idle abort", err, 1);

        // latency, stall with ready low, start ignored while busy
        fmt_word = 29'h108; data_word = 29'h1E000001; char_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("latency fetch", {char_valid, busy}, 2'b01);
        @(negedge clk);
        chk("latency first char", {char_valid, char_kind, char_data}, {1'b1, 2'd0, 4'hF});
        start = 1'b1; fmt_word = '0; data_word = '1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("stall hold %0d", i), {char_valid, char_kind, char_data}, {1'b1, 2'd0, 4'hF});
        end
        start = 1'b0; char_ready = 1'b1;
        @(negedge clk);
        chk("valid drops after xfer", char_valid, 0);
        @(negedge clk);
        chk("sign char", {char_valid, char_kind, char_data}, {1'b1, 2'd1, 4'h1});
        @(negedge clk);
        chk("stop fetch", {char_valid, done}, 2'b00);
        @(negedge clk);
        chk("done pulse", {done, busy, err, passes}, {1'b1, 1'b1, 1'b0, 8'd1});
        @(negedge clk);
        chk("back to idle", {done, busy}, 2'b00);

        // abort in EMIT with ready high, then abort beats start
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre-abort valid", char_valid, 1);
        abort = 1'b1;
        @(negedge clk);
        chk("abort to idle", {busy, done, char_valid}, 3'b000);
        start = 1'b1;
        @(negedge clk);
        chk("abort beats start", busy, 0);
        start = 1'b0; abort = 1'b0;
        load_vec(0);
        run_seq("replay", vecs[0].fmt, vecs[0].data, 1'b0);
        compare("replay", vecs[0].cycles, vecs[0].npass, vecs[0].e);

        // asynchronous reset mid-sequence
        fmt_word = 29'h020; data_word = 29'h1FE00000; char_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        #1 chk("async reset", {char_valid, char_kind, char_data, busy, done, err, passes}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        load_vec(2);
        run_seq("after reset", vecs[2].fmt, vecs[2].data, 1'b0);
        compare("after reset", vecs[2].cycles, vecs[2].npass, vecs[2].e);

        // DIGIT,RELOAD loops forever: pass counter must saturate
        fmt_word = 29'h028; data_word = 29'h1E000001; char_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (900) @(negedge clk);
        chk("passes saturate", {passes, busy, err}, {8'hFF, 1'b1, 1'b0});
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("saturate abort", {busy, done, passes}, {1'b0, 1'b0, 8'hFF});

        for (int t = 0; t < 40; t++) begin
            f = WORD_W'($urandom);
            d = WORD_W'($urandom);
            if (t % 5 == 0) d = d & 29'h1;
            for (int i = 0; i < NCODES; i++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: c = 3'd0;
                    4: c = 3'd1;
                    5: c = 3'd2;
                    6: c = 3'd3;
                    7: c = 3'd4;
                    8: c = 3'd6;
                    default: c = 3'd7;
                endcase
                f[CODE_W*i +: CODE_W] = c;
            end
            model(f, d, fe, ep, ee);
            run_seq($sformatf("rnd%0d", t), f, d, 1'b1);
            compare($sformatf("rnd%0d", t), fe + exp_kind.size(), ep, ee);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
